ladybird_mem_arbiter: RTL

- Shares one single-ported memory channel between the instruction-fetch requester (I) and the load/store requester (D) of the ladybird core.
- Registers the selected request onto the memory side and holds ownership until the memory grants it.
- Routes the grant and read data back to the owner only.
- Round-robin fairness by default; a watchdog aborts transactions the memory never grants.

---
 rtl/ladybird_mem_arbiter_if.sv | 44 ++++
 rtl/ladybird_mem_arbiter.sv | 92 +++++++++
 2 files changed

// File: rtl/ladybird_mem_arbiter_if.sv
// Handshake bundle between the ladybird I/D requesters, the arbiter and the memory channel.
// The arbiter uses the slave modport; the requester/memory environment uses master.
interface ladybird_mem_arbiter_if #(
    parameter int XLEN = 32
);
    logic              i_req;
    logic [XLEN-1:0]   i_addr;
    logic [XLEN/8-1:0] i_wstrb;
    logic [XLEN-1:0]   i_wdata;
    logic              i_gnt;
    logic [XLEN-1:0]   i_rdata;

    logic              d_req;
    logic [XLEN-1:0]   d_addr;
    logic [XLEN/8-1:0] d_wstrb;
    logic [XLEN-1:0]   d_wdata;
    logic              d_gnt;
    logic [XLEN-1:0]   d_rdata;

    logic              m_req;
    logic [XLEN-1:0]   m_addr;
    logic [XLEN/8-1:0] m_wstrb;
    logic [XLEN-1:0]   m_wdata;
    logic              m_gnt;
    logic [XLEN-1:0]   m_rdata;

    logic              err;

    modport slave (
        input  i_req, i_addr, i_wstrb, i_wdata,
        input  d_req, d_addr, d_wstrb, d_wdata,
        input  m_gnt, m_rdata,
        output i_gnt, i_rdata, d_gnt, d_rdata,
        output m_req, m_addr, m_wstrb, m_wdata, err
    );

    modport master (
        output i_req, i_addr, i_wstrb, i_wdata,
        output d_req, d_addr, d_wstrb, d_wdata,
        output m_gnt, m_rdata,
        input  i_gnt, i_rdata, d_gnt, d_rdata,
        input  m_req, m_addr, m_wstrb, m_wdata, err
    );
endinterface

// File: rtl/ladybird_mem_arbiter.sv
// Two-requester (I/D) arbiter for one memory channel with a grant watchdog.
// Define LADYBIRD_ARB_DATA_PRIO_EN for fixed D priority; round-robin otherwise.
module ladybird_mem_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  arst,
    ladybird_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        OWN_I,
        OWN_D
    } state_e;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    state_e            state_q;
    logic              mReq_q;
    logic [XLEN-1:0]   mAddr_q;
    logic [XLEN/8-1:0] mWstrb_q;
    logic [XLEN-1:0]   mWdata_q;
    logic [CW-1:0]     wdCount_q;
    logic              pickD;
    logic              owning;
    logic              timeoutHit;

`ifdef LADYBIRD_ARB_DATA_PRIO_EN
    assign pickD = bus.d_req;
`else
    logic lastD_q;
    assign pickD = bus.d_req && (!bus.i_req || !lastD_q);
`endif

    assign owning     = (state_q != IDLE);
    // Completion beats the watchdog when both land in the same cycle.
    assign timeoutHit = (TIMEOUT > 0) && owning && !bus.m_gnt && (wdCount_q == TIMEOUT_C);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= IDLE;
            mReq_q    <= 1'b0;
            mAddr_q   <= '0;
            mWstrb_q  <= '0;
            mWdata_q  <= '0;
            wdCount_q <= '0;
`ifndef LADYBIRD_ARB_DATA_PRIO_EN
            lastD_q   <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        state_q   <= pickD ? OWN_D : OWN_I;
                        mReq_q    <= 1'b1;
                        mAddr_q   <= pickD ? bus.d_addr  : bus.i_addr;
                        mWstrb_q  <= pickD ? bus.d_wstrb : bus.i_wstrb;
                        mWdata_q  <= pickD ? bus.d_wdata : bus.i_wdata;
                        wdCount_q <= '0;
`ifndef LADYBIRD_ARB_DATA_PRIO_EN
                        lastD_q   <= pickD;
`endif
                    end
                end
                default: begin
                    if (bus.m_gnt || timeoutHit) begin
                        state_q <= IDLE;
                        mReq_q  <= 1'b0;
                    end else if (wdCount_q != TIMEOUT_C) begin
                        wdCount_q <= wdCount_q + CW'(1);
                    end
                end
            endcase
        end
    end

    assign bus.m_req   = mReq_q;
    assign bus.m_addr  = mAddr_q;
    assign bus.m_wstrb = mWstrb_q;
    assign bus.m_wdata = mWdata_q;
    assign bus.err     = timeoutHit;

    // Grant and read data are steered to the current owner only.
    assign bus.i_gnt   = (state_q == OWN_I) && bus.m_gnt;
    assign bus.d_gnt   = (state_q == OWN_D) && bus.m_gnt;
    assign bus.i_rdata = bus.i_gnt ? bus.m_rdata : '0;
    assign bus.d_rdata = bus.d_gnt ? bus.m_rdata : '0;

endmodule
